// File: rtl/usb_tx_packet_builder.sv
// Builds a USB TX packet (SYNC, PID, payload, CRC16) into a packed vector from TX FIFO bytes.
// Latency: an N-byte DATA packet completes N+4 cycles after start, a handshake after 1 cycle.
// Backpressure: a FIFO pop is issued only while occupancy exceeds the byte already in flight.
module usb_tx_packet_builder #(
  parameter int MAX_DATA_BYTES = 64,
  parameter int CW = $clog2(MAX_DATA_BYTES + 1),
  parameter int LW = $clog2(MAX_DATA_BYTES + 5)
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            tx_start,
  input  logic [3:0]                      tx_pid,
  input  logic [CW-1:0]                   tx_byte_count,
  input  logic [CW-1:0]                   buffer_occupancy,
  input  logic [7:0]                      tx_packet_data,
  output logic                            get_tx_packet_data,
  output logic                            packet_busy,
  output logic                            packet_load_complete,
  output logic                            packet_error,
  output logic [LW-1:0]                   packet_length,
  output logic [8*(MAX_DATA_BYTES+4)-1:0] packet_tx
);

  localparam int PW = 8 * (MAX_DATA_BYTES + 4);

  typedef enum logic [2:0] {IDLE, FETCH, CRC_LO, CRC_HI, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, issued, captured;
  logic          inflight;
  logic [15:0]   crc;
  logic [LW-1:0] wr_idx;
  logic          is_data, is_hs, too_long, accept, reject, last_capture;

  // Reflected CRC16 (0xA001), one byte LSB-first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign is_data      = (tx_pid[1:0] == 2'b11);
  assign is_hs        = (tx_pid[1:0] == 2'b10);
  assign too_long     = (tx_byte_count > CW'(MAX_DATA_BYTES));
  assign accept       = (state == IDLE) && tx_start && (is_hs || (is_data && !too_long));
  assign reject       = (state == IDLE) && tx_start && !accept;
  assign last_capture = inflight && ((captured + CW'(1)) == count);

  assign get_tx_packet_data = (state == FETCH) && (issued < count) &&
                              (buffer_occupancy > CW'(inflight));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_hs)                   state_nxt = DONE;
          else if (tx_byte_count == '0) state_nxt = CRC_LO;
          else                         state_nxt = FETCH;
        end
      end
      FETCH:   if (last_capture) state_nxt = CRC_LO;
      CRC_LO:  state_nxt = CRC_HI;
      CRC_HI:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_idx = LW'(captured) + LW'(2);
    case (state)
      CRC_LO:  wr_idx = LW'(count) + LW'(2);
      CRC_HI:  wr_idx = LW'(count) + LW'(3);
      default: wr_idx = LW'(captured) + LW'(2);
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state                <= IDLE;
      count                <= '0;
      issued               <= '0;
      captured             <= '0;
      inflight             <= 1'b0;
      crc                  <= 16'hFFFF;
      packet_busy          <= 1'b0;
      packet_load_complete <= 1'b0;
      packet_error         <= 1'b0;
      packet_length        <= '0;
      packet_tx            <= '0;
    end else begin
      state                <= state_nxt;
      packet_busy          <= (state_nxt != IDLE);
      packet_load_complete <= (state_nxt == DONE);
      packet_error         <= reject;
      inflight             <= get_tx_packet_data;
      case (state)
        IDLE: begin
          if (accept) begin
            packet_tx     <= {{(PW-16){1'b0}}, ~tx_pid, tx_pid, 8'h80};
            crc           <= 16'hFFFF;
            count         <= is_data ? tx_byte_count : '0;
            issued        <= '0;
            captured      <= '0;
            packet_length <= is_hs ? LW'(2) : (LW'(tx_byte_count) + LW'(4));
          end
        end
        FETCH: begin
          if (get_tx_packet_data) issued <= issued + CW'(1);
          // The popped byte arrives one cycle later; land it and fold it into the CRC together.
          if (inflight) begin
            packet_tx[{wr_idx, 3'b000} +: 8] <= tx_packet_data;
            crc                              <= crc16_byte(crc, tx_packet_data);
            captured                         <= captured + CW'(1);
          end
        end
        CRC_LO:  packet_tx[{wr_idx, 3'b000} +: 8] <= ~crc[7:0];
        CRC_HI:  packet_tx[{wr_idx, 3'b000} +: 8] <= ~crc[15:8];
        default: ;
      endcase
    end
  end

endmodule
